oka_seq_mul: RTL and testbench

OKA_SEQ_MUL -- requirements
Module: oka_seq_mul

---
 rtl/oka_pkg.sv | 32 +++
 rtl/gf2_clmul.sv | 26 ++
 rtl/oka_seq_mul.sv | 167 ++++++++++++++++
 tb/tb_oka_seq_mul.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/oka_pkg.sv
// Shared types and helpers for the Karatsuba-style GF(2) sequential multiplier.
// OKA_REDUCE_EN adds the REDUCE state used for the modular-reduction build.
`timescale 1ns/1ps
package oka_pkg;

  localparam int          OKA_N_DEFAULT    = 8;
  localparam logic [8:0]  OKA_POLY_DEFAULT = 9'h11B;
  // Widest half-product the spread helper can handle.
  localparam int          OKA_SPREAD_MAX   = 64;

  typedef enum logic [2:0] {
    IDLE,
    MUL_E,
    MUL_O,
    MUL_M,
`ifdef OKA_REDUCE_EN
    REDUCE,
`endif
    DONE
  } oka_state_t;

  // Q(x) -> Q(x^2): coefficient i moves to position 2i, odd positions are zero.
  function automatic logic [2*OKA_SPREAD_MAX-1:0] spread(input logic [OKA_SPREAD_MAX-1:0] q);
    logic [2*OKA_SPREAD_MAX-1:0] r;
    r = '0;
    for (int i = 0; i < OKA_SPREAD_MAX; i++) begin
      r[2*i] = q[i];
    end
    return r;
  endfunction

endpackage

// File: rtl/gf2_clmul.sv
// Combinational W x W -> 2W-1 schoolbook carry-less (GF(2)) multiplier.
`timescale 1ns/1ps
module gf2_clmul #(
  parameter int W = 4
) (
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic [2*W-2:0] p
);

  logic [2*W-2:0] pp [W];

  generate
    for (genvar gi = 0; gi < W; gi++) begin : g_pp
      assign pp[gi] = {{(W-1){1'b0}}, a & {W{b[gi]}}} << gi;
    end
  endgenerate

  always_comb begin
    p = '0;
    for (int i = 0; i < W; i++) begin
      p = p ^ pp[i];
    end
  end

endmodule

// File: rtl/oka_seq_mul.sv
// Sequential overlap-free Karatsuba GF(2) multiplier sharing one N/2-bit clmul
// over three cycles. Define OKA_REDUCE_EN to reduce the product modulo POLY.
`timescale 1ns/1ps
module oka_seq_mul
  import oka_pkg::*;
#(
  parameter int         N    = OKA_N_DEFAULT,
  parameter logic [N:0] POLY = (N+1)'(OKA_POLY_DEFAULT)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*N-2:0] y,
  output logic           busy,
  output logic [15:0]    op_count
);

  localparam int H  = N / 2;
  localparam int PW = N - 1;
  localparam int YW = 2 * N - 1;

  oka_state_t      state_reg, state_next;
  logic [N-1:0]    a_reg, b_reg;
  logic [PW-1:0]   pe_reg, po_reg, pm_reg;
  logic [YW-1:0]   y_reg;
  logic [15:0]     op_count_reg;

  logic [H-1:0]    ae, ao, be, bo;
  logic [H-1:0]    mul_x, mul_y;
  logic [PW-1:0]   mul_p, pm_cur;
  logic [OKA_SPREAD_MAX-1:0] pe_w, po_w, mid_w;
  logic [YW-1:0]   y_comb;

  generate
    for (genvar gi = 0; gi < H; gi++) begin : g_split
      assign ae[gi] = a_reg[2*gi];
      assign ao[gi] = a_reg[2*gi+1];
      assign be[gi] = b_reg[2*gi];
      assign bo[gi] = b_reg[2*gi+1];
    end
  endgenerate

  // Operand steering for the single shared half-width multiplier.
  always_comb begin
    mul_x = ae;
    mul_y = be;
    case (state_reg)
      MUL_O: begin
        mul_x = ao;
        mul_y = bo;
      end
      MUL_M: begin
        mul_x = ae ^ ao;
        mul_y = be ^ bo;
      end
      default: ;
    endcase
  end

  gf2_clmul #(.W(H)) u_clmul (
    .a (mul_x),
    .b (mul_y),
    .p (mul_p)
  );

  // y is loaded on the MUL_M edge, so Pm comes straight from the multiplier there.
  assign pm_cur = (state_reg == MUL_M) ? mul_p : pm_reg;
  assign pe_w   = OKA_SPREAD_MAX'(pe_reg);
  assign po_w   = OKA_SPREAD_MAX'(po_reg);
  assign mid_w  = OKA_SPREAD_MAX'(pm_cur ^ pe_reg ^ po_reg);
  assign y_comb = YW'(spread(pe_w) ^ (spread(mid_w) << 1) ^ (spread(po_w) << 2));

`ifdef OKA_REDUCE_EN
  logic [YW-1:0] y_red;

  always_comb begin
    y_red = y_reg;
    for (int i = YW - 1; i >= N; i--) begin
      if (y_red[i]) begin
        y_red = y_red ^ (YW'(POLY) << (i - N));
      end
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:   if (in_valid) state_next = MUL_E;
      MUL_E:  state_next = MUL_O;
      MUL_O:  state_next = MUL_M;
`ifdef OKA_REDUCE_EN
      MUL_M:  state_next = REDUCE;
      REDUCE: state_next = DONE;
`else
      MUL_M:  state_next = DONE;
`endif
      DONE:   if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    busy      = 1'b1;
    out_valid = 1'b0;
    case (state_reg)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
      end
      DONE:    out_valid = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_reg        <= '0;
      b_reg        <= '0;
      pe_reg       <= '0;
      po_reg       <= '0;
      pm_reg       <= '0;
      y_reg        <= '0;
      op_count_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            a_reg <= a;
            b_reg <= b;
          end
        end
        MUL_E: pe_reg <= mul_p;
        MUL_O: po_reg <= mul_p;
        MUL_M: begin
          pm_reg <= mul_p;
          y_reg  <= y_comb;
        end
`ifdef OKA_REDUCE_EN
        REDUCE: y_reg <= y_red;
`endif
        DONE: begin
          if (out_ready) op_count_reg <= op_count_reg + 16'd1;
        end
        default: ;
      endcase
    end
  end

  assign y        = y_reg;
  assign op_count = op_count_reg;

endmodule

// File: tb/tb_oka_seq_mul.sv
// Scoreboard bench for oka_seq_mul (N=8); honours OKA_REDUCE_EN for expectations.
`timescale 1ns/1ps
module tb_oka_seq_mul;

  localparam int N  = 8;
  localparam int YW = 2 * N - 1;
`ifdef OKA_REDUCE_EN
  localparam int LAT = 5;
  localparam logic [YW-1:0] E_0303 = 15'h0005, E_FFFF = 15'h0013, E_00A7 = 15'h0000,
                            E_5783 = 15'h00C1, E_8080 = 15'h009A, E_01B5 = 15'h00B5;
`else
  localparam int LAT = 4;
  localparam logic [YW-1:0] E_0303 = 15'h0005, E_FFFF = 15'h5555, E_00A7 = 15'h0000,
                            E_5783 = 15'h2B79, E_8080 = 15'h4000, E_01B5 = 15'h00B5;
`endif

  typedef struct {
    logic [N-1:0]  a;
    logic [N-1:0]  b;
    logic [YW-1:0] y;
  } txn_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [N-1:0]  a = '0;
  logic [N-1:0]  b = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [YW-1:0] y;
  logic          busy;
  logic [15:0]   op_count;

  int   cyc = 0;
  int   n_cmp = 0;
  int   n_err = 0;
  int   n_txn = 0;
  txn_t exp_q[$];
  int   lat_q[$];
  logic [15:0] exp_cnt = 16'h0000;

  oka_seq_mul #(.N(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .y         (y),
    .busy      (busy),
    .op_count  (op_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got no finish required finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h required %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Bit-level schoolbook reference: every a_i*b_j term folds into x^(i+j).
  function automatic logic [YW-1:0] clmul_ref(input logic [N-1:0] x, input logic [N-1:0] z);
    logic [YW-1:0] r;
    r = '0;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        r[i+j] = r[i+j] ^ (x[i] & z[j]);
    return r;
  endfunction

  // Field multiply via repeated xtime, independent of the long-division reduction.
  function automatic logic [N-1:0] gmul_ref(input logic [N-1:0] x, input logic [N-1:0] z);
    logic [N-1:0] p;
    p = '0;
    for (int i = N - 1; i >= 0; i--) begin
      p = {p[N-2:0], 1'b0} ^ (p[N-1] ? 8'h1B : 8'h00);
      if (z[i]) p = p ^ x;
    end
    return p;
  endfunction

  function automatic logic [YW-1:0] model_y(input logic [N-1:0] x, input logic [N-1:0] z);
`ifdef OKA_REDUCE_EN
    return {7'b0, gmul_ref(x, z)};
`else
    return clmul_ref(x, z);
`endif
  endfunction

  // Monitor / scoreboard: latency on out_valid rise, data on output handshake.
  initial begin
    logic prev_ov;
    logic cnt_chk;
    txn_t t;
    int   hs;
    prev_ov = 1'b0;
    cnt_chk = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_ov = 1'b0;
        cnt_chk = 1'b0;
      end else begin
        if (cnt_chk) begin
          chk("op_count", {16'h0, op_count}, {16'h0, exp_cnt});
          cnt_chk = 1'b0;
        end
        if (in_valid && in_ready) lat_q.push_back(cyc);
        if (out_valid && !prev_ov) begin
          if (lat_q.size() == 0) begin
            chk("spurious_out_valid", 32'd1, 32'd0);
          end else begin
            hs = lat_q.pop_front();
            chk("latency", cyc - hs, LAT);
          end
        end
        prev_ov = out_valid;
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_result", {17'h0, y}, 32'hFFFF_FFFF);
          end else begin
            t = exp_q.pop_front();
            n_txn++;
            $display("txn %0d: a=%02h b=%02h y=%04h exp=%04h", n_txn, t.a, t.b, y, t.y);
            chk("y", {17'h0, y}, {17'h0, t.y});
          end
          exp_cnt = exp_cnt + 16'd1;
          cnt_chk = 1'b1;
        end
      end
    end
  end

  // Called and returns at posedge+1; waits for in_ready, records expectation at handshake.
  task automatic send(input logic [N-1:0] ta, input logic [N-1:0] tb_v, input logic [YW-1:0] ey);
    txn_t t;
    int   guard;
    guard = 0;
    in_valid = 1'b1;
    a = ta;
    b = tb_v;
    @(negedge clk);
    while (!in_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (!in_ready) begin
      chk("in_ready_timeout", 32'd0, 32'd1);
    end else begin
      t.a = ta;
      t.b = tb_v;
      t.y = ey;
      exp_q.push_back(t);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while ((exp_q.size() != 0 || busy) && guard < 200) begin
      @(posedge clk);
      #1;
      guard++;
    end
    chk("drain_timeout", exp_q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [YW-1:0] y_hold;
    int            guard;

    // Reset state
    #2;
    chk("rst_in_ready", {31'h0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'h0, out_valid}, 32'd0);
    chk("rst_busy", {31'h0, busy}, 32'd0);
    chk("rst_y", {17'h0, y}, 32'd0);
    chk("rst_op_count", {16'h0, op_count}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Directed vectors
    send(8'h03, 8'h03, E_0303);
    send(8'hFF, 8'hFF, E_FFFF);
    send(8'h00, 8'hA7, E_00A7);
    send(8'h57, 8'h83, E_5783);
    send(8'h80, 8'h80, E_8080);
    send(8'h01, 8'hB5, E_01B5);
    drain();
    chk("op_count_directed", {16'h0, op_count}, 32'd6);

    // Back-pressure: result held, new pair refused
    out_ready = 1'b0;
    send(8'h57, 8'h83, E_5783);
    guard = 0;
    while (!out_valid && guard < 20) begin
      @(posedge clk);
      #1;
      guard++;
    end
    chk("stall_reach_done", {31'h0, out_valid}, 32'd1);
    y_hold = y;
    in_valid = 1'b1;
    a = 8'hAA;
    b = 8'h55;
    repeat (10) begin
      @(negedge clk);
      chk("stall_out_valid", {31'h0, out_valid}, 32'd1);
      chk("stall_y", {17'h0, y}, {17'h0, y_hold});
      chk("stall_in_ready", {31'h0, in_ready}, 32'd0);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("stall_not_captured_busy", {31'h0, busy}, 32'd0);
    chk("stall_op_count", {16'h0, op_count}, 32'd7);

    // Asynchronous reset in MUL_O discards the operation
    send(8'hC3, 8'h5A, model_y(8'hC3, 8'h5A));
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("arst_out_valid", {31'h0, out_valid}, 32'd0);
    chk("arst_busy", {31'h0, busy}, 32'd0);
    chk("arst_in_ready", {31'h0, in_ready}, 32'd1);
    chk("arst_y", {17'h0, y}, 32'd0);
    chk("arst_op_count", {16'h0, op_count}, 32'd0);
    exp_q.delete();
    lat_q.delete();
    exp_cnt = 16'h0000;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (6) begin
      @(negedge clk);
      chk("arst_no_stale", {31'h0, out_valid}, 32'd0);
    end
    @(posedge clk);
    #1;

    // op_count wrap
    force dut.op_count_reg = 16'hFFFE;
    @(posedge clk);
    #1;
    release dut.op_count_reg;
    exp_cnt = 16'hFFFE;
    @(posedge clk);
    #1;
    chk("preload_op_count", {16'h0, op_count}, 32'h0000_FFFE);
    send(8'h03, 8'h03, E_0303);
    send(8'hFF, 8'hFF, E_FFFF);
    drain();
    chk("wrap_op_count", {16'h0, op_count}, 32'd0);
    send(8'h01, 8'hB5, E_01B5);
    drain();
    chk("post_wrap_op_count", {16'h0, op_count}, 32'd1);

    // Random pairs against the reference model
    for (int i = 0; i < 10000; i++) begin
      logic [N-1:0] ra, rb;
      ra = N'($urandom_range(0, 255));
      rb = N'($urandom_range(0, 255));
      send(ra, rb, model_y(ra, rb));
    end
    drain();
    chk("random_op_count", {16'h0, op_count}, 32'd10001);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
